// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
//   - rf_state_e    : clear-engine state (ST_IDLE, ST_CLEAR)
//   - RF_DEFAULT_W  : default entry width
//   - RF_DEFAULT_DEPTH : default entry count
//   - rf_parity()   : even parity (XOR reduction) of a zero-extended word
// Optional feature macro used by the files that import this package:
//   REGFILE_PARITY_EN
package regfile_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } rf_state_e;

    localparam int unsigned RF_DEFAULT_W     = 32;
    localparam int unsigned RF_DEFAULT_DEPTH = 32;

    // Widest word the parity helper accepts; callers zero-extend, which
    // leaves the XOR reduction unchanged.
    localparam int unsigned RF_PAR_MAX_W = 256;

    function automatic logic rf_parity(input logic [RF_PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port of regfile_mp.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (output flop -> 0)
//   i_force_zero  : clear engine active; lane registers 0
//   i_addr        : read address
//   i_ent         : array entry at i_addr (data, plus parity bit when enabled)
//   i_we0/1, i_waddr0/1, i_wdata0/1 : effective write strobes for bypass
//   o_data        : registered read data
//   o_perr        : registered parity error (REGFILE_PARITY_EN only)
// Optional feature macro: REGFILE_PARITY_EN
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DEFAULT_W,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
`ifdef REGFILE_PARITY_EN
    localparam int unsigned ENT_W   = DATA_W + 1
`else
    localparam int unsigned ENT_W   = DATA_W
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_force_zero,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ENT_W-1:0]  i_ent,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_waddr0,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_waddr1,
    input  logic [DATA_W-1:0] i_wdata1,
`ifdef REGFILE_PARITY_EN
    output logic              o_perr,
`endif
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_perr_nxt;

    always_comb begin
        w_data_nxt = i_ent[DATA_W-1:0];
`ifdef REGFILE_PARITY_EN
        w_perr_nxt = i_ent[DATA_W] ^ rf_parity(RF_PAR_MAX_W'(i_ent[DATA_W-1:0]));
`else
        w_perr_nxt = 1'b0;
`endif
        // Port 1 is checked first so it wins when both writes hit this address.
        if (i_we1 && (i_waddr1 == i_addr)) begin
            w_data_nxt = i_wdata1;
            w_perr_nxt = 1'b0;
        end else if (i_we0 && (i_waddr0 == i_addr)) begin
            w_data_nxt = i_wdata0;
            w_perr_nxt = 1'b0;
        end
        if ((ZERO_REG != 0) && (i_addr == '0)) begin
            w_data_nxt = '0;
            w_perr_nxt = 1'b0;
        end
        if (i_force_zero) begin
            w_data_nxt = '0;
            w_perr_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_data <= '0;
        else     r_data <= w_data_nxt;
    end

    assign o_data = r_data;

`ifdef REGFILE_PARITY_EN
    logic r_perr;
    always_ff @(posedge clk) begin
        if (rst) r_perr <= 1'b0;
        else     r_perr <= w_perr_nxt;
    end
    assign o_perr = r_perr;
`else
    logic w_unused_perr;
    assign w_unused_perr = w_perr_nxt;
`endif

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file, NUM_RD registered read ports,
// two prioritised write ports (port 1 wins), write-first bypass, optional
// hardwired-zero entry 0, and a sequential clear engine (one entry/cycle).
// Ports:
//   clk, rst            : clock, synchronous active-high reset (starts a clear)
//   clear_req           : pulse requesting a full clear (ignored while busy)
//   busy                : clear engine running
//   rd_addr / rd_data   : packed read ports, lane k at [k*W +: W]
//   we0/waddr0/wdata0   : write port 0 (ALU writeback)
//   we1/waddr1/wdata1   : write port 1 (load writeback, higher priority)
//   rd_perr             : per-lane parity error (REGFILE_PARITY_EN only)
// Optional feature macro: REGFILE_PARITY_EN
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DEFAULT_W,
    parameter int unsigned DEPTH    = RF_DEFAULT_DEPTH,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_req,
    output logic                     busy,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
`ifdef REGFILE_PARITY_EN
    output logic [NUM_RD-1:0]        rd_perr,
`endif
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1
);

`ifdef REGFILE_PARITY_EN
    localparam int unsigned ENT_W = DATA_W + 1;
`else
    localparam int unsigned ENT_W = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    rf_state_e         r_state;
    rf_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nxt;

    logic [ENT_W-1:0]  r_mem [DEPTH];

    logic              w_idle;
    logic              w_clr_wr;
    logic              w_we0;
    logic              w_we1;
    logic [ENT_W-1:0]  w_went0;
    logic [ENT_W-1:0]  w_went1;

    // ---------------- clear engine FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (clear_req) w_state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (r_clr_cnt == CLR_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    assign busy   = (r_state == ST_CLEAR);
    assign w_idle = (r_state == ST_IDLE) && !rst;

    // ---------------- write path ----------------
    // Effective enables already exclude dropped writes (clear, reset, entry 0),
    // so the read ports can bypass from them directly.
    assign w_clr_wr = (r_state == ST_CLEAR) && !rst;
    assign w_we0    = we0 && w_idle && !((ZERO_REG != 0) && (waddr0 == '0));
    assign w_we1    = we1 && w_idle && !((ZERO_REG != 0) && (waddr1 == '0));

`ifdef REGFILE_PARITY_EN
    assign w_went0 = {rf_parity(RF_PAR_MAX_W'(wdata0)), wdata0};
    assign w_went1 = {rf_parity(RF_PAR_MAX_W'(wdata1)), wdata1};
`else
    assign w_went0 = wdata0;
    assign w_went1 = wdata1;
`endif

    // No reset on the array: it is cleared by the engine so it can map to RAM.
    // Port 1 is written last so it overrides port 0 on an address collision.
    always_ff @(posedge clk) begin
        if (w_clr_wr) r_mem[r_clr_cnt] <= '0;
        if (w_we0)    r_mem[waddr0]    <= w_went0;
        if (w_we1)    r_mem[waddr1]    <= w_went1;
    end

    // ---------------- read ports ----------------
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [ENT_W-1:0]  w_ent;

        assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];
        assign w_ent  = r_mem[w_addr];

        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .clk          (clk),
            .rst          (rst),
            .i_force_zero (r_state == ST_CLEAR),
            .i_addr       (w_addr),
            .i_ent        (w_ent),
            .i_we0        (w_we0),
            .i_waddr0     (waddr0),
            .i_wdata0     (wdata0),
            .i_we1        (w_we1),
            .i_waddr1     (waddr1),
            .i_wdata1     (wdata1),
`ifdef REGFILE_PARITY_EN
            .o_perr       (rd_perr[k]),
`endif
            .o_data       (rd_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp with default
// parameters (DATA_W=32, DEPTH=32, NUM_RD=2, ZERO_REG=1).
// Optional feature macro: REGFILE_PARITY_EN (adds rd_perr checks).
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_req;
    logic        busy;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
`ifdef REGFILE_PARITY_EN
    logic [1:0]  rd_perr;
`endif
    logic        we0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        we1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W   (32),
        .DEPTH    (32),
        .NUM_RD   (2),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .busy      (busy),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
`ifdef REGFILE_PARITY_EN
        .rd_perr   (rd_perr),
`endif
        .we0       (we0),
        .waddr0    (waddr0),
        .wdata0    (wdata0),
        .we1       (we1),
        .waddr1    (waddr1),
        .wdata1    (wdata1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic chk_perr(input string tag);
`ifdef REGFILE_PARITY_EN
        chk(tag, {30'd0, rd_perr}, 32'd0);
`endif
    endtask

    // Counts busy cycles from now (including this one), checking the read
    // lanes stay zero throughout; bounded so a stuck engine cannot hang.
    task automatic count_busy(input string tag, input logic pulse_at5);
        int unsigned n;
        n = 0;
        while (busy && n < 100) begin
            chk({tag, "_rd0"}, rd_data[31:0], 32'd0);
            chk({tag, "_rd1"}, rd_data[63:32], 32'd0);
            chk_perr({tag, "_perr"});
            n++;
            clear_req = (pulse_at5 && n == 5);
            step();
        end
        clear_req = 1'b0;
        chk({tag, "_cycles"}, n, 32'd32);
        chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a));
            step();
            chk({tag, "_p0"}, rd_data[31:0], 32'd0);
            chk({tag, "_p1"}, rd_data[63:32], 32'd0);
            chk_perr({tag, "_perr"});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clear_req = 1'b0;
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        set_rd(5'd31, 5'd5);
        step();
        step();
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_rd", rd_data[31:0], 32'd0);
        chk("rst_rd1", rd_data[63:32], 32'd0);
        chk_perr("rst_perr");
        rst = 1'b0;

        // Reset-initiated clear: 32 busy cycles, then everything reads 0.
        count_busy("clr0", 1'b0);
        read_all_zero("zero0");

        // Write then read back on both ports.
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        set_rd(5'd1, 5'd2);
        step();
        we0 = 1'b0;
        set_rd(5'd5, 5'd5);
        step();
        chk("wr5_p0", rd_data[31:0], 32'hDEADBEEF);
        chk("wr5_p1", rd_data[63:32], 32'hDEADBEEF);
        chk_perr("wr5_perr");

        // Collision: port 1 wins.
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11111111;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22222222;
        set_rd(5'd5, 5'd1);
        step();
        we0 = 1'b0; we1 = 1'b0;
        set_rd(5'd7, 5'd5);
        step();
        chk("coll_p0", rd_data[31:0], 32'h22222222);
        chk("coll_p1", rd_data[63:32], 32'hDEADBEEF);

        // Bypass: same-cycle write and read of 9.
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h12345678;
        step();
        wdata0 = 32'hCAFEF00D;
        set_rd(5'd5, 5'd9);
        step();
        we0 = 1'b0;
        chk("byp_p1", rd_data[63:32], 32'hCAFEF00D);
        chk("byp_p0", rd_data[31:0], 32'hDEADBEEF);
        chk_perr("byp_perr");

        // Two-port bypass: port 1 data is forwarded.
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hAAAA0000;
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'hBBBB0000;
        set_rd(5'd9, 5'd7);
        step();
        we0 = 1'b0; we1 = 1'b0;
        chk("byp2_p0", rd_data[31:0], 32'hBBBB0000);
        chk("byp2_p1", rd_data[63:32], 32'h22222222);
        step();
        chk("byp2_hold", rd_data[31:0], 32'hBBBB0000);

        // Zero register: writes to 0 dropped, reads of 0 give 0 even with bypass.
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h0F0F0F0F;
        set_rd(5'd0, 5'd0);
        step();
        we0 = 1'b0; we1 = 1'b0;
        chk("zero_byp_p0", rd_data[31:0], 32'd0);
        chk("zero_byp_p1", rd_data[63:32], 32'd0);
        step();
        chk("zero_rd_p0", rd_data[31:0], 32'd0);
        chk("zero_rd_p1", rd_data[63:32], 32'd0);
        chk_perr("zero_perr");

        // Fill 1..31, then clear mid-operation.
        for (int a = 1; a < 32; a++) begin
            we0 = 1'b1; waddr0 = 5'(a); wdata0 = 32'hA5000000 | 32'(a);
            step();
        end
        we0 = 1'b0;
        set_rd(5'd31, 5'd3);
        step();
        chk("fill_31", rd_data[31:0], 32'hA500001F);
        chk("fill_3", rd_data[63:32], 32'hA5000003);

        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk("clr_busy", {31'd0, busy}, 32'd1);
        // Write during clear must be ignored.
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h33333333;
        step();
        we0 = 1'b0;
        chk("clr_rd_zero", rd_data[63:32], 32'd0);
        for (int i = 0; i < 9; i++) begin
            step();
        end
        // Clear counter now at 10; reset restarts the clear.
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy("clr1", 1'b1);
        read_all_zero("zero1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
